// File: rtl/hilo_mult_if.sv
// HI/LO multiply unit request/response bundle.
// Master drives requests, slave returns status, results and HI/LO.
interface hilo_mult_if;
    logic        Start;
    logic [4:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        MtHi;
    logic        MtLo;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic        ResultValid;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, ALUOp, A, B, MtHi, MtLo,
        input  Busy, Done, Result, ResultValid, HI, LO
    );

    modport slave (
        input  Start, ALUOp, A, B, MtHi, MtLo,
        output Busy, Done, Result, ResultValid, HI, LO
    );
endinterface

// File: rtl/hilo_mult_unit.sv
// EX-stage multi-cycle HI/LO multiply/accumulate unit.
// Shift-add multiplier on magnitudes, sign fixed up in the ACC cycle.
module hilo_mult_unit #(
    parameter int BITS_PER_CYCLE = 2
) (
    input logic      Clk,
    input logic      Rst,
    hilo_mult_if.slave bus
);
    localparam int N  = 32 / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;

    localparam logic [4:0] OP_MULTU = 5'd26;
    localparam logic [4:0] OP_MFLO  = 5'd27;
    localparam logic [4:0] OP_MFHI  = 5'd28;
    localparam logic [4:0] OP_MSUB  = 5'd29;
    localparam logic [4:0] OP_MADD  = 5'd30;
    localparam logic [4:0] OP_MUL   = 5'd31;

    logic [1:0]    state;
    logic [4:0]    op;
    logic          neg;
    logic [63:0]   mcand;
    logic [31:0]   mplier;
    logic [63:0]   prod;
    logic [CW-1:0] cnt;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   result;
    logic          done;
    logic          rv;

    logic          is_multi;
    logic          is_signed;
    logic [31:0]   a_abs;
    logic [31:0]   b_abs;
    logic [63:0]   pp;
    logic [63:0]   p_fin;

    assign is_multi  = (bus.ALUOp == OP_MULTU) || (bus.ALUOp == OP_MADD) ||
                       (bus.ALUOp == OP_MSUB)  || (bus.ALUOp == OP_MUL);
    assign is_signed = (bus.ALUOp != OP_MULTU);
    assign a_abs     = bus.A[31] ? -bus.A : bus.A;
    assign b_abs     = bus.B[31] ? -bus.B : bus.B;
    assign p_fin     = neg ? -prod : prod;

    // Partial products for the multiplier bits retired this cycle.
    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) pp = pp + (mcand << i);
        end
    end

    // Op sequencing, multiplier datapath and HI/LO/Result ownership.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            op     <= '0;
            neg    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            done   <= 1'b0;
            rv     <= 1'b0;
        end else begin
            done <= 1'b0;
            rv   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Start && is_multi) begin
                        op     <= bus.ALUOp;
                        mcand  <= {32'b0, is_signed ? a_abs : bus.A};
                        mplier <= is_signed ? b_abs : bus.B;
                        neg    <= is_signed & (bus.A[31] ^ bus.B[31]);
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= MULT;
                    end else begin
                        if (bus.Start && bus.ALUOp == OP_MFHI) begin
                            result <= hi;
                            rv     <= 1'b1;
                        end
                        if (bus.Start && bus.ALUOp == OP_MFLO) begin
                            result <= lo;
                            rv     <= 1'b1;
                        end
                        if (bus.MtHi) hi <= bus.A;
                        if (bus.MtLo) lo <= bus.A;
                    end
                end
                MULT: begin
                    prod   <= prod + pp;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) state <= ACC;
                end
                ACC: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    case (op)
                        OP_MULTU: {hi, lo} <= p_fin;
                        OP_MADD:  {hi, lo} <= {hi, lo} + p_fin;
                        OP_MSUB:  {hi, lo} <= {hi, lo} - p_fin;
                        OP_MUL: begin
                            result <= p_fin[31:0];
                            rv     <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy        = (state != IDLE);
    assign bus.Done        = done;
    assign bus.ResultValid = rv;
    assign bus.Result      = result;
    assign bus.HI          = hi;
    assign bus.LO          = lo;
endmodule
